msg_schedule: RTL and testbench

MSG_SCHEDULE -- requirements
Module: msg_schedule

---
 rtl/sha256_pkg.sv | 20 ++
 rtl/msg_schedule_if.sv | 14 +
 rtl/w_expand.sv | 15 +
 rtl/msg_schedule.sv | 71 +++++++
 tb/tb_msg_schedule.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/sha256_pkg.sv
// sha256_pkg: SHA-256 round constants, schedule sizing and FSM state type.
package sha256_pkg;
  localparam int ROUNDS = 64;
  localparam int WORD_W = 32;
  localparam logic [5:0] LAST_RND = 6'(ROUNDS - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  localparam logic [WORD_W-1:0] K [ROUNDS] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  function automatic logic [WORD_W-1:0] ror(input logic [WORD_W-1:0] x, input int n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction
endpackage

// File: rtl/msg_schedule_if.sv
// msg_schedule_if: block request and round-word output bundle of the message scheduler.
interface msg_schedule_if import sha256_pkg::*; ;
  logic              start_i;
  logic [511:0]      block_i;
  logic              en_i;
  logic [WORD_W-1:0] w_o;
  logic [WORD_W-1:0] k_o;
  logic              sel_o;
  logic [5:0]        round_o;
  logic              busy_o;
  logic              done_o;
  modport slave (input start_i, block_i, en_i, output w_o, k_o, sel_o, round_o, busy_o, done_o);
  modport master (output start_i, block_i, en_i, input w_o, k_o, sel_o, round_o, busy_o, done_o);
endinterface

// File: rtl/w_expand.sv
// w_expand: next schedule word from the four window taps the recurrence needs.
module w_expand import sha256_pkg::*; (
  input  logic [WORD_W-1:0] w0_i,
  input  logic [WORD_W-1:0] w1_i,
  input  logic [WORD_W-1:0] w9_i,
  input  logic [WORD_W-1:0] w14_i,
  output logic [WORD_W-1:0] w_o
);
  logic [WORD_W-1:0] s0, s1;
  always_comb begin
    s0  = ror(w1_i, 7) ^ ror(w1_i, 18) ^ (w1_i >> 3);
    s1  = ror(w14_i, 17) ^ ror(w14_i, 19) ^ (w14_i >> 10);
    w_o = s1 + w9_i + s0 + w0_i;
  end
endmodule

// File: rtl/msg_schedule.sv
// msg_schedule: SHA-256 message schedule issuing one W[t]/K[t] pair per enabled round.
module msg_schedule import sha256_pkg::*; (
  input  logic          clk,
  input  logic          rst_n,
  msg_schedule_if.slave bus
);
  state_e                 state_q, state_d;
  logic [15:0][WORD_W-1:0] win_q, win_d;
  logic [WORD_W-1:0]      w_q, w_d, nw;
  logic [5:0]             rnd_q, rnd_d, rnd_o_q, rnd_o_d;
  logic                   sel_q, sel_d, act_q, act_d, busy_q, busy_d, done_q, done_d;

  w_expand u_expand (.w0_i(win_q[0]), .w1_i(win_q[1]), .w9_i(win_q[9]), .w14_i(win_q[14]), .w_o(nw));

  // act_q marks that a round has been issued in this RUN, so stalls hold it rather than zero it
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    rnd_d   = rnd_q;
    sel_d   = 1'b0;
    done_d  = 1'b0;
    act_d   = (state_q == RUN) && (bus.en_i || act_q);
    if (state_q == IDLE && bus.start_i) begin
      state_d = RUN;
      rnd_d   = '0;
      for (int i = 0; i < 16; i++) win_d[i] = bus.block_i[511-32*i -: 32];
    end else if (state_q == RUN && bus.en_i) begin
      sel_d   = 1'b1;
      win_d   = {nw, win_q[15:1]};
      rnd_d   = rnd_q + 6'd1;
      state_d = (rnd_q == LAST_RND) ? DONE : RUN;
    end else if (state_q == DONE) begin
      state_d = IDLE;
      done_d  = 1'b1;
    end
    w_d     = sel_d ? win_q[0] : act_d ? w_q : '0;
    rnd_o_d = sel_d ? rnd_q : act_d ? rnd_o_q : '0;
    busy_d  = state_d != IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      win_q   <= '0;
      rnd_q   <= '0;
      rnd_o_q <= '0;
      w_q     <= '0;
      sel_q   <= 1'b0;
      act_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      rnd_q   <= rnd_d;
      rnd_o_q <= rnd_o_d;
      w_q     <= w_d;
      sel_q   <= sel_d;
      act_q   <= act_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.w_o     = w_q;
  assign bus.k_o     = act_q ? K[rnd_o_q] : '0;
  assign bus.sel_o   = sel_q;
  assign bus.round_o = rnd_o_q;
  assign bus.busy_o  = busy_q;
  assign bus.done_o  = done_q;
endmodule

// File: tb/tb_msg_schedule.sv
// tb_msg_schedule: scoreboard bench for msg_schedule with an independent SHA-256 compression model.
module tb_msg_schedule;
  typedef struct packed {logic [5:0] r; logic [31:0] w;} exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cyc = 0, errors = 0, checks = 0, sel_cnt = 0;
  int n, n2, d, base;
  exp_t sb[$];
  exp_t e;
  logic [31:0] mw [64];
  logic [31:0] wk [8];
  logic [31:0] t1, t2;
  logic [255:0] iv, abc_hash;
  logic [511:0] abc, rb;
  logic busy_prev = 1'b0;

  msg_schedule_if ifc();
  msg_schedule dut (.clk(clk), .rst_n(rst_n), .bus(ifc));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rr(input logic [31:0] x, input int s);
    return (x >> s) | (x << (32 - s));
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic load_model(input logic [511:0] b);
    for (int t = 0; t < 64; t++) begin
      if (t < 16) mw[t] = b[511-32*t -: 32];
      else mw[t] = (rr(mw[t-2], 17) ^ rr(mw[t-2], 19) ^ (mw[t-2] >> 10)) + mw[t-7]
                 + (rr(mw[t-15], 7) ^ rr(mw[t-15], 18) ^ (mw[t-15] >> 3)) + mw[t-16];
      sb.push_back('{r: 6'(t), w: mw[t]});
    end
  endtask

  task automatic start_blk(input logic [511:0] b, output int acc);
    load_model(b);
    ifc.block_i = b;
    ifc.start_i = 1'b1;
    @(posedge clk);
    #1 acc = cyc;
    ifc.start_i = 1'b0;
  endtask

  task automatic at_cyc(input int c);
    @(negedge clk);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_done(output int dc);
    dc = -1;
    for (int i = 0; i < 200 && dc < 0; i++) begin
      @(negedge clk);
      if (ifc.done_o) dc = cyc;
    end
    if (dc < 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic chk_hash(input logic [255:0] exp);
    for (int i = 0; i < 8; i++) chk($sformatf("hash%0d", i), wk[i] + iv[255-32*i -: 32], exp[255-32*i -: 32]);
  endtask

  task automatic rand_blk(output logic [511:0] b);
    for (int i = 0; i < 16; i++) b[511-32*i -: 32] = $urandom();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_w"}, ifc.w_o, 32'd0);
    chk({tag, "_k"}, ifc.k_o, 32'd0);
    chk({tag, "_sel"}, 32'(ifc.sel_o), 32'd0);
    chk({tag, "_round"}, 32'(ifc.round_o), 32'd0);
    chk({tag, "_busy"}, 32'(ifc.busy_o), 32'd0);
    chk({tag, "_done"}, 32'(ifc.done_o), 32'd0);
  endtask

  // Scoreboard pop plus compression driven only by what the DUT issues
  always @(negedge clk) begin
    if (!rst_n) sb.delete();
    if (ifc.busy_o && !busy_prev) for (int i = 0; i < 8; i++) wk[i] = iv[255-32*i -: 32];
    busy_prev = ifc.busy_o;
    if (ifc.sel_o) begin
      sel_cnt++;
      if (sb.size() == 0) chk("extra_sel", 32'(ifc.round_o), 32'hffffffff);
      else begin
        e = sb.pop_front();
        chk("sb_w", ifc.w_o, e.w);
        chk("sb_round", 32'(ifc.round_o), 32'(e.r));
      end
      t1 = wk[7] + (rr(wk[4], 6) ^ rr(wk[4], 11) ^ rr(wk[4], 25)) + ((wk[4] & wk[5]) ^ (~wk[4] & wk[6]))
         + ifc.k_o + ifc.w_o;
      t2 = (rr(wk[0], 2) ^ rr(wk[0], 13) ^ rr(wk[0], 22)) + ((wk[0] & wk[1]) ^ (wk[0] & wk[2]) ^ (wk[1] & wk[2]));
      wk[7] = wk[6]; wk[6] = wk[5]; wk[5] = wk[4]; wk[4] = wk[3] + t1;
      wk[3] = wk[2]; wk[2] = wk[1]; wk[1] = wk[0]; wk[0] = t1 + t2;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    iv = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    abc_hash = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    abc = {32'h61626380, 448'h0, 32'h00000018};
    ifc.start_i = 1'b0;
    ifc.en_i = 1'b0;
    ifc.block_i = '0;
    @(negedge clk);
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    ifc.en_i = 1'b1;
    // abc block, no stalls
    @(negedge clk);
    base = sel_cnt;
    start_blk(abc, n);
    at_cyc(n + 1);
    chk("abc_w0", ifc.w_o, 32'h61626380);
    chk("abc_k0", ifc.k_o, 32'h428a2f98);
    chk("abc_sel0", 32'(ifc.sel_o), 32'd1);
    at_cyc(n + 17);
    chk("abc_w16", ifc.w_o, 32'h61626380);
    at_cyc(n + 18);
    chk("abc_w17", ifc.w_o, 32'h000f0000);
    at_cyc(n + 64);
    chk("abc_k63", ifc.k_o, 32'hc67178f2);
    chk("abc_round63", 32'(ifc.round_o), 32'd63);
    wait_done(d);
    chk("abc_done_lat", 32'(d - n), 32'd65);
    chk("abc_sel_cnt", 32'(sel_cnt - base), 32'd64);
    chk_hash(abc_hash);
    @(negedge clk);
    chk_zero("idle");
    // stall rounds 10..12 on a random block
    rand_blk(rb);
    base = sel_cnt;
    start_blk(rb, n);
    at_cyc(n + 11);
    chk("stall_pre_round", 32'(ifc.round_o), 32'd10);
    ifc.en_i = 1'b0;
    at_cyc(n + 13);
    chk("stall_sel", 32'(ifc.sel_o), 32'd0);
    chk("stall_round", 32'(ifc.round_o), 32'd10);
    chk("stall_w", ifc.w_o, mw[10]);
    at_cyc(n + 14);
    ifc.en_i = 1'b1;
    wait_done(d);
    chk("stall_done_lat", 32'(d - n), 32'd68);
    chk("stall_sel_cnt", 32'(sel_cnt - base), 32'd64);
    // start during RUN is ignored
    @(negedge clk);
    base = sel_cnt;
    start_blk(abc, n);
    at_cyc(n + 20);
    rand_blk(rb);
    ifc.block_i = rb;
    ifc.start_i = 1'b1;
    @(negedge clk);
    ifc.start_i = 1'b0;
    wait_done(d);
    chk("ign_done_lat", 32'(d - n), 32'd65);
    chk("ign_sel_cnt", 32'(sel_cnt - base), 32'd64);
    chk("ign_sb_empty", 32'(sb.size()), 32'd0);
    chk_hash(abc_hash);
    // reset mid-run
    @(negedge clk);
    start_blk(abc, n);
    at_cyc(n + 31);
    chk("rst_pre_round", 32'(ifc.round_o), 32'd30);
    #1 rst_n = 1'b0;
    #1 chk_zero("midrst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rand_blk(rb);
    base = sel_cnt;
    start_blk(rb, n);
    at_cyc(n + 1);
    chk("restart_w0", ifc.w_o, mw[0]);
    chk("restart_round0", 32'(ifc.round_o), 32'd0);
    wait_done(d);
    chk("restart_done_lat", 32'(d - n), 32'd65);
    chk("restart_sel_cnt", 32'(sel_cnt - base), 32'd64);
    // back-to-back blocks
    @(negedge clk);
    base = sel_cnt;
    rand_blk(rb);
    start_blk(rb, n);
    wait_done(d);
    rand_blk(rb);
    start_blk(rb, n2);
    chk("b2b_accept", 32'(n2 - n), 32'd66);
    at_cyc(n2 + 1);
    chk("b2b_first_sel", 32'(ifc.sel_o), 32'd1);
    chk("b2b_first_round", 32'(ifc.round_o), 32'd0);
    at_cyc(n2 + 64);
    chk("b2b_last_sel", 32'(ifc.sel_o), 32'd1);
    chk("b2b_last_round", 32'(ifc.round_o), 32'd63);
    wait_done(d);
    chk("b2b_done_lat", 32'(d - n2), 32'd65);
    chk("b2b_sel_cnt", 32'(sel_cnt - base), 32'd128);
    chk("b2b_sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
